down_counter_reload: RTL and testbench
======================================

Name: down_counter_reload

Overview:
- Loadable down-counter and terminal-count timer; the counting-down, expiry-signalling counterpart of the team's loadable up counter.
- Parallel load sets the start value. Counts down under enable, flags terminal count and optionally auto-reloads.
- Used as a programmable delay/period generator beside the up counters in the same clock domain.

Parameters:
- WIDTH, 8, bit width of data, out and internal reload register.

Ports:
- clk  input  1  clock input; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 at posedge clk resets the block).
- data  input  WIDTH  parallel load value for the counter.
- load  input  1  parallel load enable.
- enable  input  1  count enable (decrement one per cycle).
- auto_reload  input  1  1 = periodic mode (reload on terminal count), 0 = one-shot.
- out  output  WIDTH  current counter value (registered).
- busy  output  1  registered; 1 while state is RUN.
- done  output  1  registered; 1 while state is DONE (one-shot expiry, held until next load).
- tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, named reset.
- Reset (reset==0 at posedge): out=0, reload_val=0, state=IDLE, busy=0, done=0, tc=0. Reset overrides load/enable; reset mid-count aborts with no tc pulse.
- State machine IDLE / RUN / DONE; priority reset > load > enable.
- Load (any state):
  - out<=data, reload_val<=data, tc<=0.
  - data!=0: next state RUN.
  - data==0: next state IDLE, done=0.
- RUN, enable=0: hold out; tc=0.
- RUN, enable=1, out>1: out<=out-1, tc=0.
- RUN, enable=1, out==1 (terminal decrement), tc<=1 the same edge, so tc is high in the cycle where the new value is visible:
  - auto_reload=1: out<=reload_val, stay RUN.
  - auto_reload=0: out<=0, next state DONE.
- auto_reload is sampled only at the terminal decrement edge.
- IDLE / DONE with enable=1: out stays 0 (saturating, no wrap to all-ones), tc=0.
- DONE persists until load or reset.
- Load coincident with terminal decrement: load wins, tc=0, no reload.
- reload_val==1 with auto_reload=1: tc high on every enabled cycle; out stays 1.
- Latency: load to out visible is 1 cycle. Count sequence N, N-1, ..., 1, then 0 or reload; tc after exactly N enabled cycles from load.
- Width: unsigned modulo-2^WIDTH arithmetic; the decrement never executes at out==0.
- busy = (state==RUN); done = (state==DONE). Both registered outputs, no combinational path from inputs.

Optional Feature:
- Macro DCNT_TC_STICKY_EN.
- Defined:
  - Adds input tc_clr (1 bit) and output tc_sticky (1 bit).
  - tc_sticky sets on any cycle tc is asserted and holds until tc_clr==1 at a posedge.
  - Simultaneous set and clear: set wins.
  - Reset clears tc_sticky to 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset: drive reset=0 for 2 cycles with load=1, data=8'h55 -> out=0, busy=0, done=0, tc=0; after release out stays 0 with enable=1.
- One-shot: load data=3, auto_reload=0, enable=1 continuous -> out 3,2,1,0; tc high only in the cycle out becomes 0; then done=1, busy=0; out holds 0 for 5 more cycles.
- Periodic: load data=4, auto_reload=1, enable=1 for 12 cycles -> out 4,3,2,1,4,3,2,1,4,... with tc pulsing every 4th cycle; done never asserts.
- Pause/collision: load 5, enable toggled 1,0,0,1 -> out 5,4,4,4,3. With out==1, assert load data=9 with enable=1 -> out=9, tc=0, busy=1.
- Edge values: load data=0 -> state IDLE, busy=0, no tc. Load data=1 with auto_reload=1 -> tc high every enabled cycle, out stays 1. Reset asserted mid-count at out=2 -> out=0, tc never pulses.
- DCNT_TC_STICKY_EN: one-shot from 2 -> tc_sticky=1 after expiry and held. tc_clr=1 in a cycle with a tc pulse (periodic, data=1) -> tc_sticky stays 1. tc_clr=1 without tc -> tc_sticky=0.

Source files
------------

// File: rtl/down_counter_reload.sv
// Loadable down-counter / terminal-count timer with optional periodic auto-reload.
// Optional feature macro: DCNT_TC_STICKY_EN adds tc_clr input and tc_sticky output.
module down_counter_reload #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
`ifdef DCNT_TC_STICKY_EN
  input  logic             tc_clr,
  output logic             tc_sticky,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_last;
  logic             w_zero;

  assign w_last = (r_out == WIDTH'(1));
  assign w_zero = (r_out == '0);

  // Next-state logic: load beats enable; the decrement is never taken at zero.
  always_comb begin
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    if (load) begin
      w_out_nxt    = data;
      w_reload_nxt = data;
      w_state_nxt  = (data != '0) ? S_RUN : S_IDLE;
    end else if (enable) begin
      case (r_state)
        S_RUN: begin
          if (w_last) begin
            w_tc_nxt = 1'b1;
            if (auto_reload) begin
              w_out_nxt = r_reload;
            end else begin
              w_out_nxt   = '0;
              w_state_nxt = S_DONE;
            end
          end else if (!w_zero) begin
            w_out_nxt = r_out - WIDTH'(1);
          end
        end
        default: begin
          w_out_nxt = r_out;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_out    <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_busy   <= (w_state_nxt == S_RUN);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;
  assign tc   = r_tc;

`ifdef DCNT_TC_STICKY_EN
  logic r_tc_sticky;

  // Captures any cycle in which tc was high; a set in the same cycle as tc_clr wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tc_sticky <= 1'b0;
    end else if (r_tc) begin
      r_tc_sticky <= 1'b1;
    end else if (tc_clr) begin
      r_tc_sticky <= 1'b0;
    end
  end

  assign tc_sticky = r_tc_sticky;
`endif

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: behavioural model checked every cycle plus literal checkpoints.
module tb_down_counter_reload;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data;
  logic             load;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             tc;
`ifdef DCNT_TC_STICKY_EN
  logic             tc_clr;
  logic             tc_sticky;
`endif

  int n_vec = 0;
  int n_bad = 0;

  down_counter_reload #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .load        (load),
    .enable      (enable),
    .auto_reload (auto_reload),
`ifdef DCNT_TC_STICKY_EN
    .tc_clr      (tc_clr),
    .tc_sticky   (tc_sticky),
`endif
    .out         (out),
    .busy        (busy),
    .done        (done),
    .tc          (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a remaining-count timer with running/expired flags.
  int m_out = 0, m_reload = 0;
  bit m_running = 0, m_expired = 0, m_tc = 0, m_sticky = 0, m_valid = 0;

  always @(posedge clk) begin
`ifdef DCNT_TC_STICKY_EN
    if (!reset) m_sticky = 0;
    else if (m_tc) m_sticky = 1;
    else if (tc_clr) m_sticky = 0;
`endif
    if (!reset) begin
      m_out = 0; m_reload = 0; m_running = 0; m_expired = 0; m_tc = 0;
    end else if (load) begin
      m_out = int'(data); m_reload = int'(data); m_tc = 0;
      m_running = (data != 0); m_expired = 0;
    end else if (enable && m_running) begin
      if (m_out == 1) begin
        m_tc = 1;
        if (auto_reload) m_out = m_reload;
        else begin m_out = 0; m_running = 0; m_expired = 1; end
      end else begin
        m_out = m_out - 1; m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out", 32'(out), 32'(m_out));
      chk("model_busy", 32'(busy), 32'(m_running));
      chk("model_done", 32'(done), 32'(m_expired));
      chk("model_tc", 32'(tc), 32'(m_tc));
`ifdef DCNT_TC_STICKY_EN
      chk("model_sticky", 32'(tc_sticky), 32'(m_sticky));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] o, input logic b, input logic d, input logic t);
    chk({name, "_out"}, 32'(out), 32'(o));
    chk({name, "_busy"}, 32'(busy), 32'(b));
    chk({name, "_done"}, 32'(done), 32'(d));
    chk({name, "_tc"}, 32'(tc), 32'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int tc_count;
    logic [7:0] per_exp [12];
    per_exp = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
    reset = 1'b0; load = 1'b1; data = 8'h55; enable = 1'b0; auto_reload = 1'b0;
`ifdef DCNT_TC_STICKY_EN
    tc_clr = 1'b0;
`endif
    // Reset dominates a concurrent load
    cyc(); cyc();
    lit("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; load = 1'b0; enable = 1'b1;
    cyc(); cyc();
    lit("post_reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // One-shot from 3
    load = 1'b1; data = 8'd3;
    cyc(); lit("os_load", 8'd3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    cyc(); lit("os_2", 8'd2, 1'b1, 1'b0, 1'b0);
    cyc(); lit("os_1", 8'd1, 1'b1, 1'b0, 1'b0);
    cyc(); lit("os_tc", 8'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(); lit("os_hold", 8'd0, 1'b0, 1'b1, 1'b0);
    end

    // Periodic from 4
    load = 1'b1; data = 8'd4; auto_reload = 1'b1;
    cyc(); lit("per_load", 8'd4, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    tc_count = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("per_out", 32'(out), 32'(per_exp[i]));
      chk("per_done", 32'(done), 32'd0);
      if (tc) tc_count++;
    end
    chk("per_tc_count", 32'(tc_count), 32'd3);

    // Pause and load collision at terminal decrement
    auto_reload = 1'b0; load = 1'b1; data = 8'd5;
    cyc(); lit("pause_load", 8'd5, 1'b1, 1'b0, 1'b0);
    load = 1'b0; enable = 1'b1; cyc(); chk("pause_a", 32'(out), 32'd4);
    enable = 1'b0;              cyc(); chk("pause_b", 32'(out), 32'd4);
                                cyc(); chk("pause_c", 32'(out), 32'd4);
    enable = 1'b1;              cyc(); chk("pause_d", 32'(out), 32'd3);
    cyc(); cyc(); chk("coll_pre", 32'(out), 32'd1);
    load = 1'b1; data = 8'd9;
    cyc(); lit("collide", 8'd9, 1'b1, 1'b0, 1'b0);

    // Load zero stays idle
    data = 8'd0;
    cyc(); lit("zero_load", 8'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    cyc(); cyc(); lit("zero_en", 8'd0, 1'b0, 1'b0, 1'b0);

    // Reload value 1 in periodic mode
    load = 1'b1; data = 8'd1; auto_reload = 1'b1;
    cyc(); lit("one_load", 8'd1, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); lit("one_per", 8'd1, 1'b1, 1'b0, 1'b1);
    end

    // Reset mid-count aborts silently
    load = 1'b1; data = 8'd4; auto_reload = 1'b0;
    cyc(); load = 1'b0;
    cyc(); cyc(); chk("abort_pre", 32'(out), 32'd2);
    reset = 1'b0;
    cyc(); lit("abort", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); lit("abort_after", 8'd0, 1'b0, 1'b0, 1'b0);
    end

`ifdef DCNT_TC_STICKY_EN
    chk("sticky_rst", 32'(tc_sticky), 32'd0);
    load = 1'b1; data = 8'd2;
    cyc(); load = 1'b0;
    cyc(); cyc(); chk("sticky_tc", 32'(tc), 32'd1);
    cyc(); chk("sticky_set", 32'(tc_sticky), 32'd1);
    cyc(); chk("sticky_hold", 32'(tc_sticky), 32'd1);
    tc_clr = 1'b1;
    cyc(); chk("sticky_clr", 32'(tc_sticky), 32'd0);
    tc_clr = 1'b0; load = 1'b1; data = 8'd1; auto_reload = 1'b1;
    cyc(); load = 1'b0;
    cyc(); cyc(); chk("sticky_per", 32'(tc_sticky), 32'd1);
    tc_clr = 1'b1;
    cyc(); chk("sticky_setwins", 32'(tc_sticky), 32'd1);
    tc_clr = 1'b0;
`endif

    load = 1'b0; enable = 1'b0;
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
